// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM behind the SPI slave: 10-bit words in,
// read data out, with independent write/read address FSMs and error tracking.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [0:0] W_NOADDR = 1'b0;
  localparam logic [0:0] W_ADDR   = 1'b1;
  localparam logic [0:0] R_NOADDR = 1'b0;
  localparam logic [0:0] R_ADDR   = 1'b1;

  localparam int                   IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0]           DEPTH_9   = 9'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [0:0]           r_wr_state;
  logic [0:0]           r_rd_state;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic [1:0] w_cmd;
  logic [7:0] w_payload;
  logic       w_in_range;
  logic       w_wr_addr_ok;
  logic       w_wr_data_ok;
  logic       w_rd_addr_ok;
  logic       w_rd_data_ok;
  logic       w_reject;

  assign w_cmd      = rx_data[9:8];
  assign w_payload  = rx_data[7:0];
  assign w_in_range = {1'b0, w_payload} < DEPTH_9;

  // Each word belongs to exactly one FSM, so at most one of these is set.
  assign w_wr_addr_ok = rx_valid && (w_cmd == CMD_WR_ADDR) && w_in_range;
  assign w_wr_data_ok = rx_valid && (w_cmd == CMD_WR_DATA) && (r_wr_state == W_ADDR);
  assign w_rd_addr_ok = rx_valid && (w_cmd == CMD_RD_ADDR) && w_in_range;
  assign w_rd_data_ok = rx_valid && (w_cmd == CMD_RD_DATA) && (r_rd_state == R_ADDR);

  assign w_reject = rx_valid && !(w_wr_addr_ok || w_wr_data_ok || w_rd_addr_ok || w_rd_data_ok);

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] addr);
    if (AUTO_INC == 0)      return addr;
    if (addr == LAST_ADDR)  return '0;
    return addr + ADDR_SIZE'(1);
  endfunction

  // NOTE: RAM has no reset so it maps onto a block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_data_ok) r_mem[r_wr_addr[IDX_W-1:0]] <= w_payload;
  end

  // NOTE: all state updates use <= so every read below sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_NOADDR;
      r_rd_state <= R_NOADDR;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= w_reject;
      if (w_reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      if (w_wr_addr_ok) begin
        r_wr_addr  <= ADDR_SIZE'(w_payload);
        r_wr_state <= W_ADDR;
      end
      if (w_wr_data_ok) r_wr_addr <= next_addr(r_wr_addr);

      if (w_rd_addr_ok) begin
        r_rd_addr  <= ADDR_SIZE'(w_payload);
        r_rd_state <= R_ADDR;
      end
      if (w_rd_data_ok) begin
        tx_data   <= r_mem[r_rd_addr[IDX_W-1:0]];
        tx_valid  <= 1'b1;
        r_rd_addr <= next_addr(r_rd_addr);
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: table-driven vectors on a 256-deep and a 128-deep
// instance, read data tracked through a scoreboard queue, plus reset sequences.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data, rx128_data;
  logic       rx_valid, rx128_valid;
  logic [7:0] tx_data, tx128_data, err_cnt, err128_cnt;
  logic       tx_valid, tx128_valid, cmd_err, cmd128_err;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err), .err_cnt(err_cnt)
  );

  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(1)) dut128 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx128_data), .rx_valid(rx128_valid),
    .tx_data(tx128_data), .tx_valid(tx128_valid), .cmd_err(cmd128_err), .err_cnt(err128_cnt)
  );

  typedef struct {
    logic       valid;
    logic [9:0] word;
    logic       exp_err;
    logic [7:0] exp_cnt;
    logic       exp_tx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl[$];
  vec_t       tbl128[$];
  logic [7:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic vec_t vec(input logic valid, input logic [9:0] word, input logic e,
                               input logic [7:0] c, input logic t, input logic [7:0] d);
    vec_t r;
    r.valid = valid; r.word = word; r.exp_err = e;
    r.exp_cnt = c;   r.exp_tx = t;  r.exp_data = d;
    return r;
  endfunction

  // Drive one word, clock it in, sample 1 ns after the edge, then release rx_valid.
  task automatic step(input bit sel, input vec_t t, input string tag);
    logic       e, tv;
    logic [7:0] c, d;
    if (t.exp_tx) sb.push_back(t.exp_data);
    if (sel) begin rx128_valid = t.valid; rx128_data = t.word; end
    else     begin rx_valid    = t.valid; rx_data    = t.word; end
    @(posedge clk);
    #1;
    if (sel) begin e = cmd128_err; c = err128_cnt; tv = tx128_valid; d = tx128_data; end
    else     begin e = cmd_err;    c = err_cnt;    tv = tx_valid;    d = tx_data;    end
    check({tag, " cmd_err"},  e,  t.exp_err);
    check({tag, " err_cnt"},  c,  t.exp_cnt);
    check({tag, " tx_valid"}, tv, t.exp_tx);
    check({tag, " tx_data"},  d,  t.exp_data);
    if (tv) begin
      if (sb.size() == 0) check({tag, " unexpected_tx"}, tv, 1'b0);
      else                check({tag, " sb_data"}, d, sb.pop_front());
    end
    rx_valid    = 1'b0;
    rx128_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx128_valid = 1'b0;
    rx_data = '0; rx128_data = '0;

    // 256-deep instance: illegal-before-address, write/read, wrap, RAW, idle word.
    tbl.push_back(vec(1, 10'h1AA, 1, 8'd1, 0, 8'h00));
    tbl.push_back(vec(1, 10'h300, 1, 8'd2, 0, 8'h00));
    tbl.push_back(vec(1, 10'h010, 0, 8'd2, 0, 8'h00));
    tbl.push_back(vec(1, 10'h15A, 0, 8'd2, 0, 8'h00));
    tbl.push_back(vec(1, 10'h210, 0, 8'd2, 0, 8'h00));
    tbl.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'h5A));
    tbl.push_back(vec(0, 10'h000, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h0FE, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h111, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h122, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h133, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h2FE, 0, 8'd2, 0, 8'h5A));
    tbl.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'h11));
    tbl.push_back(vec(1, 10'h3A5, 0, 8'd2, 1, 8'h22));
    tbl.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'h33));
    tbl.push_back(vec(1, 10'h020, 0, 8'd2, 0, 8'h33));
    tbl.push_back(vec(1, 10'h1C3, 0, 8'd2, 0, 8'h33));
    tbl.push_back(vec(1, 10'h220, 0, 8'd2, 0, 8'h33));
    tbl.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'hC3));
    tbl.push_back(vec(1, 10'h020, 0, 8'd2, 0, 8'hC3));
    tbl.push_back(vec(0, 10'h1FF, 0, 8'd2, 0, 8'hC3));
    tbl.push_back(vec(1, 10'h220, 0, 8'd2, 0, 8'hC3));
    tbl.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'hC3));
    tbl.push_back(vec(0, 10'h300, 0, 8'd2, 0, 8'hC3));

    // 128-deep instance: range checks and wrap at 7F.
    tbl128.push_back(vec(1, 10'h005, 0, 8'd0, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h1AB, 0, 8'd0, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h080, 1, 8'd1, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h1CD, 0, 8'd1, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h280, 1, 8'd2, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h206, 0, 8'd2, 0, 8'h00));
    tbl128.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'hCD));
    tbl128.push_back(vec(1, 10'h27F, 0, 8'd2, 0, 8'hCD));
    tbl128.push_back(vec(1, 10'h07F, 0, 8'd2, 0, 8'hCD));
    tbl128.push_back(vec(1, 10'h177, 0, 8'd2, 0, 8'hCD));
    tbl128.push_back(vec(1, 10'h188, 0, 8'd2, 0, 8'hCD));
    tbl128.push_back(vec(1, 10'h27F, 0, 8'd2, 0, 8'hCD));
    tbl128.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'h77));
    tbl128.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'h88));
    tbl128.push_back(vec(1, 10'h205, 0, 8'd2, 0, 8'h88));
    tbl128.push_back(vec(1, 10'h300, 0, 8'd2, 1, 8'hAB));

    #2;
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst cmd_err",  cmd_err,  1'b0);
    check("rst err_cnt",  err_cnt,  8'h00);
    check("rst tx_data",  tx_data,  8'h00);
    #10 rst_n = 1'b1;

    for (int i = 0; i < tbl128.size(); i++) step(1'b1, tbl128[i], $sformatf("d128[%0d]", i));
    for (int i = 0; i < tbl.size(); i++)    step(1'b0, tbl[i],    $sformatf("vec[%0d]", i));

    // Saturation: write-data with no address is rejected every time.
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b0, vec(1, 10'h100, 1, (i >= 254) ? 8'hFF : 8'(i + 1), 0, 8'h00),
           $sformatf("sat[%0d]", i));
    end
    step(1'b0, vec(1, 10'h210, 0, 8'hFF, 0, 8'h00), "sat rd_addr");
    step(1'b0, vec(1, 10'h300, 0, 8'hFF, 1, 8'h5A), "sat rd_data");

    // Reset while tx_valid is still high from the read just taken.
    rst_n = 1'b0;
    #1;
    check("midrst tx_valid", tx_valid, 1'b0);
    check("midrst err_cnt",  err_cnt,  8'h00);
    check("midrst cmd_err",  cmd_err,  1'b0);
    check("midrst tx_data",  tx_data,  8'h00);
    #2 rst_n = 1'b1;

    step(1'b0, vec(1, 10'h100, 1, 8'd1, 0, 8'h00), "post wr_noaddr");
    step(1'b0, vec(1, 10'h300, 1, 8'd2, 0, 8'h00), "post rd_noaddr");
    step(1'b0, vec(1, 10'h210, 0, 8'd2, 0, 8'h00), "post rd_addr10");
    step(1'b0, vec(1, 10'h300, 0, 8'd2, 1, 8'h5A), "post retain10");
    step(1'b0, vec(1, 10'h220, 0, 8'd2, 0, 8'h5A), "post rd_addr20");
    step(1'b0, vec(1, 10'h300, 0, 8'd2, 1, 8'hC3), "post retain20");

    check("sb drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
